lane_align_ctrl: RTL
====================

// Module: lane_align_ctrl
// PURPOSE
//  Training/bit-slip controller for the LVDS ADC capture path. Checks each lane's
//  2-bit {fall,rise} slice of the assembled sample word against a fixed training
//  pattern and pulses per-lane bitslip until every enabled lane matches.
//  Declares lock or failure. Sits beside the word assembler in the dco_clk domain.
// PARAMETERS
//  LANES          8          number of capture lanes; sample word is 2*LANES bits
//  LANE_PAT       2'b10      expected per-lane slice {bit_fall,bit_rise} during training
//  LANE_MASK      {LANES{1}} lanes checked; masked lanes: never slipped, never fail
//  MATCH_COUNT    16         consecutive all-lane-match valid words required for lock
//  SETTLE_CYCLES  8          dco_clk cycles ignored after a slip (pipeline refill)
//  MAX_SLIPS      3          slips per lane before that lane is declared failed
// PORTS
//  dco_clk      in   1        capture clock
//  rst_n        in   1        asynchronous active-low reset
//  train_start  in   1        1-cycle pulse: (re)start training
//  sample_word  in   2*LANES  assembled word; lane i = bits [2i+1:2i]
//  word_valid   in   1        sample_word valid this cycle
//  bitslip      out  LANES    1-cycle slip pulse per lane
//  busy         out  1        training in progress (FLUSH/CHECK/SLIP)
//  locked       out  1        all enabled lanes aligned
//  fail         out  1        training aborted; some lane exceeded MAX_SLIPS
//  fail_lanes   out  LANES    lanes that exceeded MAX_SLIPS (valid while fail=1)
// BEHAVIOUR
//  Clock and reset:
//  - Single clock dco_clk; rst_n is asynchronous, active-low.
//  - Reset: state=IDLE; bitslip=0, busy=0, locked=0, fail=0, fail_lanes=0;
//    all counters 0.
//  States: IDLE, FLUSH, CHECK, SLIP, LOCKED, FAIL. All outputs registered.
//  - IDLE: wait. train_start -> FLUSH.
//  - FLUSH: count SETTLE_CYCLES dco_clk edges, ignoring word_valid -> CHECK.
//    Entering FLUSH from train_start also clears slip counters, match counter
//    and fail_lanes.
//  - CHECK: act only on word_valid=1. Define mis[i] = LANE_MASK[i] &
//    (slice_i != LANE_PAT).
//    - mis==0: match_cnt++. Reaching MATCH_COUNT -> LOCKED.
//    - mis!=0: match_cnt=0. If any lane with mis[i] has slip_cnt[i]==MAX_SLIPS,
//      go to FAIL and set fail_lanes = those lanes. Otherwise go to SLIP and
//      latch mis.
//    - word_valid=0 holds all counters.
//  - SLIP: bitslip = latched mis for exactly one cycle, slip_cnt[i]++ for those
//    lanes, then -> FLUSH. Slip counters are not cleared in this path.
//  - LOCKED: locked=1, busy=0. train_start -> FLUSH with locked dropping in
//    that same cycle. Other behaviour depends on LANE_ALIGN_MONITOR_EN.
//  - FAIL: fail=1, busy=0, fail_lanes held. train_start -> FLUSH.
//  Outputs: busy=1 exactly in FLUSH/CHECK/SLIP; locked/fail are mutually exclusive.
//  Boundary rules:
//  - train_start in any state (including mid-SLIP or FLUSH) restarts at FLUSH;
//    any pending bitslip pulse still completes its single cycle.
//  - Counter widths: settle $clog2(SETTLE_CYCLES+1), match $clog2(MATCH_COUNT+1),
//    slip $clog2(MAX_SLIPS+1). Counters saturate and never wrap.
//  - MAX_SLIPS=0: first mismatch -> FAIL.
//  - LANE_MASK=0: lock after MATCH_COUNT valid words.
// CONFIGURATION
//  LANE_ALIGN_MONITOR_EN defined:
//  - In LOCKED, any word_valid word with mis!=0 clears locked, pulses lock_lost
//    (extra 1-bit output port, reset 0) for 1 cycle, and -> FLUSH with slip
//    counters preserved.
//  LANE_ALIGN_MONITOR_EN undefined:
//  - No lock_lost port. LOCKED ignores sample_word and is left only via
//    train_start.
// TESTING (LANES=8, LANE_PAT=2'b10, MATCH_COUNT=4, SETTLE_CYCLES=3, MAX_SLIPS=3)
//  1. Every lane 2'b10, word_valid=1 continuous, pulse train_start -> bitslip
//     never asserted; locked rises 3 flush + 4 check cycles after FLUSH entry;
//     busy=0 once locked.
//  2. Lane 3 reads 2'b01 until 1 slip, then 2'b10 -> one bitslip=8'h08 pulse,
//     3-cycle re-flush, then lock.
//  3. Lane 5 never matches -> bitslip=8'h20 three times, then fail=1,
//     fail_lanes=8'h20, locked=0.
//  4. LANE_MASK=8'h7F with lane 7 stuck at 2'b00 -> no slip on lane 7; lock
//     as in test 1.
//  5. word_valid toggling 1/0 in CHECK -> lock only after 4 valid words; mid-
//     FLUSH train_start restarts the settle count.
//  6. Async rst_n low during SLIP -> all outputs 0 immediately. MONITOR_EN:
//     mismatch in LOCKED -> lock_lost 1 cycle, re-train, re-lock.

Source files
------------

// File: rtl/lane_align_ctrl.sv
// ---------------------------------------------------------------------------
// lane_align_ctrl
//   Training and bit-slip controller for the LVDS ADC capture path. Each
//   lane's 2-bit {fall,rise} slice of the assembled sample word is compared
//   against a fixed training pattern. Lanes that do not match get a one-cycle
//   bitslip pulse. After each slip the controller waits for the capture
//   pipeline to refill, then checks again. This repeats until every enabled
//   lane matches for MATCH_COUNT consecutive valid words (lock), or until some
//   lane has used up MAX_SLIPS slips (fail).
//
//   Optional feature macro: LANE_ALIGN_MONITOR_EN
//     When defined, the controller keeps checking words while LOCKED. Any
//     mismatch drops lock, pulses lock_lost and re-trains. The slip history
//     is kept across this re-train.
//     When undefined, LOCKED ignores sample_word and there is no lock_lost port.
//
// Ports
//   dco_clk      in   capture clock
//   rst_n        in   asynchronous active-low reset
//   train_start  in   1-cycle pulse, (re)starts training from any state
//   sample_word  in   assembled word; lane i = bits [2i+1:2i]
//   word_valid   in   sample_word valid this cycle
//   bitslip      out  per-lane 1-cycle slip pulse
//   busy         out  training in progress (FLUSH/CHECK/SLIP)
//   locked       out  all enabled lanes aligned
//   fail         out  training aborted, a lane exceeded MAX_SLIPS
//   fail_lanes   out  lanes that exceeded MAX_SLIPS (valid while fail=1)
//   lock_lost    out  (LANE_ALIGN_MONITOR_EN only) 1-cycle lock-drop pulse
// ---------------------------------------------------------------------------
module lane_align_ctrl #(
  parameter int               LANES         = 8,
  parameter logic [1:0]       LANE_PAT      = 2'b10,
  parameter logic [LANES-1:0] LANE_MASK     = {LANES{1'b1}},
  parameter int               MATCH_COUNT   = 16,
  parameter int               SETTLE_CYCLES = 8,
  parameter int               MAX_SLIPS     = 3
) (
  input  logic               dco_clk,
  input  logic               rst_n,
  input  logic               train_start,
  input  logic [2*LANES-1:0] sample_word,
  input  logic               word_valid,
  output logic [LANES-1:0]   bitslip,
  output logic               busy,
  output logic               locked,
  output logic               fail,
`ifdef LANE_ALIGN_MONITOR_EN
  output logic [LANES-1:0]   fail_lanes,
  output logic               lock_lost
`else
  output logic [LANES-1:0]   fail_lanes
`endif
);

  // A zero-valued parameter would give a zero-width counter, so each width
  // is forced to at least one bit.
  localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int MW = (MATCH_COUNT   > 0) ? $clog2(MATCH_COUNT   + 1) : 1;
  localparam int KW = (MAX_SLIPS     > 0) ? $clog2(MAX_SLIPS     + 1) : 1;

  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [MW-1:0] MATCH_LAST  = MW'((MATCH_COUNT   > 0) ? MATCH_COUNT   - 1 : 0);
  localparam logic [MW-1:0] MATCH_MAX   = MW'(MATCH_COUNT);
  localparam logic [KW-1:0] SLIP_MAX    = KW'(MAX_SLIPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_CHECK,
    S_SLIP,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t          state;
  logic [SW-1:0]   settle_cnt;
  logic [MW-1:0]   match_cnt;
  logic [KW-1:0]   slip_cnt [LANES];

  logic [LANES-1:0] mis;     // enabled lanes whose slice is wrong this cycle
  logic [LANES-1:0] at_max;  // lanes with no slip budget left

  // NOTE: every output of a combinational block gets a default before any
  // conditional logic, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    mis    = '0;
    at_max = '0;
    for (int i = 0; i < LANES; i++) begin
      mis[i]    = LANE_MASK[i] && (sample_word[2*i +: 2] != LANE_PAT);
      at_max[i] = (int'(slip_cnt[i]) >= MAX_SLIPS);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Later
  // assignments in the same block override the per-cycle defaults at the top.
  always_ff @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      bitslip    <= '0;
      busy       <= 1'b0;
      locked     <= 1'b0;
      fail       <= 1'b0;
      fail_lanes <= '0;
      settle_cnt <= '0;
      match_cnt  <= '0;
      // NOTE: the slip counters are a small register array, not a RAM, so
      // resetting every entry is cheap and keeps the start state deterministic.
      for (int i = 0; i < LANES; i++) slip_cnt[i] <= '0;
`ifdef LANE_ALIGN_MONITOR_EN
      lock_lost  <= 1'b0;
`endif
    end else begin
      // bitslip is driven only on the CHECK->SLIP edge. It is therefore high
      // for exactly the one cycle spent in SLIP, even if a restart interrupts it.
      bitslip <= '0;
`ifdef LANE_ALIGN_MONITOR_EN
      lock_lost <= 1'b0;
`endif
      if (train_start) begin
        state      <= S_FLUSH;
        busy       <= 1'b1;
        locked     <= 1'b0;
        fail       <= 1'b0;
        fail_lanes <= '0;
        settle_cnt <= '0;
        match_cnt  <= '0;
        for (int i = 0; i < LANES; i++) slip_cnt[i] <= '0;
      end else begin
        case (state)
          S_IDLE: ;

          // Let the assembler pipeline refill. Words seen here are stale.
          S_FLUSH: begin
            if (settle_cnt >= SETTLE_LAST) begin
              state      <= S_CHECK;
              settle_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end

          S_CHECK: begin
            if (word_valid) begin
              if (mis == '0) begin
                if (match_cnt != MATCH_MAX) match_cnt <= match_cnt + 1'b1;
                if (match_cnt >= MATCH_LAST) begin
                  state  <= S_LOCKED;
                  busy   <= 1'b0;
                  locked <= 1'b1;
                end
              end else begin
                match_cnt <= '0;
                if ((mis & at_max) != '0) begin
                  state      <= S_FAIL;
                  busy       <= 1'b0;
                  fail       <= 1'b1;
                  fail_lanes <= mis & at_max;
                end else begin
                  state   <= S_SLIP;
                  bitslip <= mis;
                end
              end
            end
          end

          // bitslip still holds the lanes latched on entry; charge them a slip.
          S_SLIP: begin
            for (int i = 0; i < LANES; i++) begin
              if (bitslip[i] && (slip_cnt[i] != SLIP_MAX)) slip_cnt[i] <= slip_cnt[i] + 1'b1;
            end
            state      <= S_FLUSH;
            settle_cnt <= '0;
          end

          S_LOCKED: begin
`ifdef LANE_ALIGN_MONITOR_EN
            if (word_valid && (mis != '0)) begin
              state      <= S_FLUSH;
              busy       <= 1'b1;
              locked     <= 1'b0;
              lock_lost  <= 1'b1;
              settle_cnt <= '0;
              match_cnt  <= '0;
            end
`endif
          end

          S_FAIL: ;

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
